// File: rtl/w0rm_core_branch_ras.sv
// w0rm_core_branch_ras: branch resolution unit with a return-address stack.
// Evaluates the condition code against the ALU flags and selects the branch
// target from the stack, a relative offset, or a register. It also maintains
// a circular return stack for calls and returns. All results are registered
// one cycle after acceptance and held under backpressure.
module w0rm_core_branch_ras #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int USER_WIDTH  = 1,
    parameter int RAS_DEPTH   = 4,
    parameter int LINK_OFFSET = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    // upstream
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          is_branch,
    input  logic [3:0]                    cond_code,
    input  logic                          is_link,
    input  logic                          is_return,
    input  logic                          rel_abs,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [DATA_WIDTH-1:0]         rn,
    input  logic [DATA_WIDTH-1:0]         lit,
    input  logic                          flag_z,
    input  logic                          flag_n,
    input  logic                          flag_c,
    input  logic                          flag_v,
    input  logic [USER_WIDTH-1:0]         user_in,
    // downstream
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_WIDTH-1:0]         next_pc,
    output logic                          next_pc_valid,
    output logic                          flush_pipeline,
    output logic                          link_valid,
    output logic [DATA_WIDTH-1:0]         link_data,
    output logic                          ras_overflow,
    output logic                          ras_underflow,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic [USER_WIDTH-1:0]         user_out
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [3:0] {
        CC_ZS = 4'd0,  CC_ZC = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3,
        CC_VS = 4'd4,  CC_VC = 4'd5,  CC_NS = 4'd6,  CC_NC = 4'd7,
        CC_GE = 4'd8,  CC_LT = 4'd9,  CC_GT = 4'd10, CC_LE = 4'd11,
        CC_HI = 4'd12, CC_LS = 4'd13, CC_AL = 4'd14, CC_NV = 4'd15
    } cond_e;

    // Return stack storage, top-of-stack pointer and occupancy.
    logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]      top_ptr;
    logic [CNT_W-1:0]      count_q;

    logic                  accept;
    logic                  cond_met;
    logic                  taken;
    logic                  stack_empty;
    logic                  stack_full;
    logic [ADDR_WIDTH-1:0] link_addr;
    logic [ADDR_WIDTH-1:0] target;
    logic [PTR_W-1:0]      ptr_nxt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  ovf_nxt;
    logic                  unf_nxt;

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign stack_empty = (count_q == '0);
    assign stack_full  = (count_q == CNT_W'(RAS_DEPTH));
    assign link_addr   = base_addr + ADDR_WIDTH'(LINK_OFFSET);
    assign taken       = is_branch && cond_met;
    assign ras_count   = count_q;

    // Condition-code decode against the ALU flags.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path through the block can infer a latch.
        cond_met = 1'b0;
        unique case (cond_e'(cond_code))
            CC_ZS: cond_met = flag_z;
            CC_ZC: cond_met = !flag_z;
            CC_CS: cond_met = flag_c;
            CC_CC: cond_met = !flag_c;
            CC_VS: cond_met = flag_v;
            CC_VC: cond_met = !flag_v;
            CC_NS: cond_met = flag_n;
            CC_NC: cond_met = !flag_n;
            CC_GE: cond_met = (flag_n == flag_v);
            CC_LT: cond_met = (flag_n != flag_v);
            CC_GT: cond_met = !flag_z && (flag_n == flag_v);
            CC_LE: cond_met = flag_z || (flag_n != flag_v);
            CC_HI: cond_met = flag_c && !flag_z;
            CC_LS: cond_met = !flag_c || flag_z;
            CC_AL: cond_met = 1'b1;
            CC_NV: cond_met = 1'b0;
        endcase
    end

    // Target selection: stack top for a return with data, else relative or absolute.
    always_comb begin
        if (is_return && !stack_empty)
            target = ras_mem[top_ptr];
        else if (rel_abs)
            target = base_addr + lit[ADDR_WIDTH-1:0];
        else
            target = rn[ADDR_WIDTH-1:0];
    end

    // Next stack state: pop, push (overwriting oldest when full), or replace top.
    always_comb begin
        ptr_nxt = top_ptr;
        cnt_nxt = count_q;
        wr_en   = 1'b0;
        wr_ptr  = top_ptr;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (taken) begin
            if (is_return && !stack_empty) begin
                if (is_link) begin
                    // Call-through-return: top was read for the target, now replaced.
                    wr_en = 1'b1;
                end else begin
                    ptr_nxt = top_ptr - 1'b1;
                    cnt_nxt = count_q - 1'b1;
                end
            end else begin
                unf_nxt = is_return;
                if (is_link) begin
                    // When full, top+1 wraps onto the oldest entry.
                    ptr_nxt = top_ptr + 1'b1;
                    wr_ptr  = top_ptr + 1'b1;
                    wr_en   = 1'b1;
                    ovf_nxt = stack_full;
                    cnt_nxt = stack_full ? count_q : count_q + 1'b1;
                end
            end
        end
    end

    // Stack entry writes on accepted pushes/replacements.
    always_ff @(posedge clk) begin
        // NOTE: the stack storage has no reset; the count defines which entries
        // are live, so clearing the array would only cost reset fan-out.
        if (accept && wr_en)
            ras_mem[wr_ptr] <= link_addr;
    end

    // Registered result and stack pointer/count; hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            out_valid      <= 1'b0;
            next_pc        <= '0;
            next_pc_valid  <= 1'b0;
            flush_pipeline <= 1'b0;
            link_valid     <= 1'b0;
            link_data      <= '0;
            ras_overflow   <= 1'b0;
            ras_underflow  <= 1'b0;
            user_out       <= '0;
            top_ptr        <= '0;
            count_q        <= '0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            next_pc        <= taken ? target : '0;
            next_pc_valid  <= taken;
            flush_pipeline <= taken;
            link_valid     <= taken && is_link;
            link_data      <= (taken && is_link) ? DATA_WIDTH'(link_addr) : '0;
            ras_overflow   <= ovf_nxt;
            ras_underflow  <= unf_nxt;
            user_out       <= user_in;
            top_ptr        <= ptr_nxt;
            count_q        <= cnt_nxt;
        end else if (out_ready) begin
            // Result consumed with nothing new: drop valid and per-result strobes.
            out_valid      <= 1'b0;
            next_pc_valid  <= 1'b0;
            flush_pipeline <= 1'b0;
            link_valid     <= 1'b0;
            ras_overflow   <= 1'b0;
            ras_underflow  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_w0rm_core_branch_ras.sv
// Directed self-checking bench for w0rm_core_branch_ras (default parameters).
module tb_w0rm_core_branch_ras;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, is_branch, is_link, is_return, rel_abs;
    logic [3:0]  cond_code;
    logic [31:0] base_addr, rn, lit;
    logic        flag_z, flag_n, flag_c, flag_v;
    logic [0:0]  user_in, user_out;
    logic        out_valid, out_ready, next_pc_valid, flush_pipeline, link_valid;
    logic [31:0] next_pc, link_data;
    logic        ras_overflow, ras_underflow;
    logic [2:0]  ras_count;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    w0rm_core_branch_ras dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .is_branch(is_branch),
        .cond_code(cond_code), .is_link(is_link), .is_return(is_return),
        .rel_abs(rel_abs), .base_addr(base_addr), .rn(rn), .lit(lit),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .user_in(user_in),
        .out_valid(out_valid), .out_ready(out_ready), .next_pc(next_pc),
        .next_pc_valid(next_pc_valid), .flush_pipeline(flush_pipeline),
        .link_valid(link_valid), .link_data(link_data),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
        .ras_count(ras_count), .user_out(user_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic br, input logic [3:0] cc, input logic lnk,
                          input logic ret, input logic rel, input logic [31:0] b,
                          input logic [31:0] r, input logic [31:0] l, input logic u);
        in_valid  = 1'b1;
        is_branch = br;
        cond_code = cc;
        is_link   = lnk;
        is_return = ret;
        rel_abs   = rel;
        base_addr = b;
        rn        = r;
        lit       = l;
        user_in   = u;
    endtask

    task automatic set_flags(input logic z, input logic n, input logic c, input logic v);
        flag_z = z; flag_n = n; flag_c = c; flag_v = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; is_branch = 1'b0; cond_code = 4'd0; is_link = 1'b0;
        is_return = 1'b0; rel_abs = 1'b0; base_addr = '0; rn = '0; lit = '0;
        user_in = 1'b0; out_ready = 1'b1;
        set_flags(0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_next_pc", next_pc, 0);
        chk("rst_ras_count", ras_count, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Relative unconditional
        set_op(1, 4'd14, 0, 0, 1, 32'h100, 32'h0, 32'h20, 1'b1);
        tick();
        chk("rel_out_valid", out_valid, 1);
        chk("rel_next_pc", next_pc, 32'h120);
        chk("rel_flush", flush_pipeline, 1);
        chk("rel_npc_valid", next_pc_valid, 1);
        chk("rel_user_out", user_out, 1);
        chk("rel_link_valid", link_valid, 0);

        // GT taken (Z=0, N=V=1) -> absolute rn
        set_op(1, 4'd10, 0, 0, 0, 32'h100, 32'h400, 32'h0, 1'b0);
        set_flags(0, 1, 0, 1);
        tick();
        chk("gt_taken_pc", next_pc, 32'h400);
        chk("gt_taken_valid", next_pc_valid, 1);
        // same op, Z=1 -> not taken
        set_flags(1, 1, 0, 1);
        tick();
        chk("gt_nt_valid", next_pc_valid, 0);
        chk("gt_nt_pc", next_pc, 0);
        chk("gt_nt_flush", flush_pipeline, 0);
        chk("gt_nt_out_valid", out_valid, 1);

        // V set taken
        set_op(1, 4'd4, 0, 0, 0, 32'h0, 32'h444, 32'h0, 1'b0);
        set_flags(0, 0, 0, 1);
        tick();
        chk("vs_pc", next_pc, 32'h444);
        // LS with C=1, Z=0 -> not taken
        set_op(1, 4'd13, 0, 0, 0, 32'h0, 32'h555, 32'h0, 1'b0);
        set_flags(0, 0, 1, 0);
        tick();
        chk("ls_nt_valid", next_pc_valid, 0);
        // HI with C=1, Z=0 -> taken
        set_op(1, 4'd12, 0, 0, 0, 32'h0, 32'h666, 32'h0, 1'b0);
        tick();
        chk("hi_pc", next_pc, 32'h666);
        // NEVER
        set_op(1, 4'd15, 0, 0, 0, 32'h0, 32'h777, 32'h0, 1'b0);
        tick();
        chk("nv_valid", next_pc_valid, 0);
        // Non-branch link op: no link, no push
        set_op(0, 4'd14, 1, 0, 1, 32'h80, 32'h0, 32'h4, 1'b0);
        tick();
        chk("nb_valid", next_pc_valid, 0);
        chk("nb_link_valid", link_valid, 0);
        chk("nb_ras_count", ras_count, 0);
        set_flags(0, 0, 0, 0);

        // Call / return
        set_op(1, 4'd14, 1, 0, 1, 32'h200, 32'h0, 32'h40, 1'b0);
        tick();
        chk("call_pc", next_pc, 32'h240);
        chk("call_link_valid", link_valid, 1);
        chk("call_link_data", link_data, 32'h202);
        chk("call_count", ras_count, 1);
        set_op(1, 4'd14, 0, 1, 0, 32'h240, 32'h0, 32'h0, 1'b0);
        tick();
        chk("ret_pc", next_pc, 32'h202);
        chk("ret_count", ras_count, 0);
        chk("ret_unf", ras_underflow, 0);

        // Five links -> overflow on the fifth
        for (int i = 1; i <= 5; i++) begin
            set_op(1, 4'd14, 1, 0, 1, 32'(i * 16), 32'h0, 32'h0, 1'b0);
            tick();
            chk($sformatf("push%0d_count", i), ras_count, (i < 4) ? i : 4);
            chk($sformatf("push%0d_ovf", i), ras_overflow, (i == 5) ? 1 : 0);
        end

        // Five returns -> 0x52, 0x42, 0x32, 0x22, then rn with underflow
        begin
            logic [31:0] exp_pc [5];
            exp_pc[0] = 32'h52; exp_pc[1] = 32'h42; exp_pc[2] = 32'h32;
            exp_pc[3] = 32'h22; exp_pc[4] = 32'h999;
            for (int i = 0; i < 5; i++) begin
                set_op(1, 4'd14, 0, 1, 0, 32'h0, 32'h999, 32'h0, 1'b0);
                tick();
                chk($sformatf("pop%0d_pc", i), next_pc, exp_pc[i]);
                chk($sformatf("pop%0d_count", i), ras_count, (i < 4) ? 3 - i : 0);
                chk($sformatf("pop%0d_unf", i), ras_underflow, (i == 4) ? 1 : 0);
            end
        end

        // Link + return replaces the top
        set_op(1, 4'd14, 1, 0, 1, 32'h300, 32'h0, 32'h0, 1'b0);
        tick();
        set_op(1, 4'd14, 1, 1, 0, 32'h500, 32'h0, 32'h0, 1'b0);
        tick();
        chk("lr_pc", next_pc, 32'h302);
        chk("lr_link_data", link_data, 32'h502);
        chk("lr_count", ras_count, 1);
        chk("lr_flags", {ras_overflow, ras_underflow}, 0);
        set_op(1, 4'd14, 0, 1, 0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        chk("lr_ret_pc", next_pc, 32'h502);
        chk("lr_ret_count", ras_count, 0);

        // Drain
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        set_op(1, 4'd14, 0, 0, 1, 32'h1000, 32'h0, 32'h1, 1'b1);
        tick();
        chk("bp_a_pc", next_pc, 32'h1001);
        set_op(1, 4'd14, 0, 0, 1, 32'h2000, 32'h0, 32'h2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold%0d_ready", i), in_ready, 0);
            tick();
            chk($sformatf("bp_hold%0d_pc", i), next_pc, 32'h1001);
            chk($sformatf("bp_hold%0d_user", i), user_out, 1);
            chk($sformatf("bp_hold%0d_valid", i), out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_b_pc", next_pc, 32'h2002);
        chk("bp_b_user", user_out, 0);
        set_op(1, 4'd14, 0, 0, 1, 32'h3000, 32'h0, 32'h3, 1'b0);
        tick();
        chk("bp_c_pc", next_pc, 32'h3003);
        in_valid = 1'b0;
        tick();
        chk("bp_end_valid", out_valid, 0);

        // Reset mid-op
        set_op(1, 4'd14, 1, 0, 1, 32'h700, 32'h0, 32'h10, 1'b1);
        tick();
        chk("mid_pre_valid", out_valid, 1);
        chk("mid_pre_count", ras_count, 1);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_next_pc", next_pc, 0);
        chk("mid_flush", flush_pipeline, 0);
        chk("mid_link_valid", link_valid, 0);
        chk("mid_link_data", link_data, 0);
        chk("mid_count", ras_count, 0);
        chk("mid_user", user_out, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/w0rm_core_branch_ras.md
W0RM_CORE_BRANCH_RAS -- requirements
Module: w0rm_core_branch_ras

Interface
REQ-001 SHALL have parameters: DATA_WIDTH 32, data width; ADDR_WIDTH 32, PC width, ADDR_WIDTH <= DATA_WIDTH; USER_WIDTH 1, sideband width; RAS_DEPTH 4, return-stack entries, power of 2 and >= 2; LINK_OFFSET 2, link address minus base address.
REQ-002 SHALL have one clock; reset is asynchronous and active-high: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-003 SHALL have upstream ports: in_valid  in  1  op present; in_ready  out  1  op accepted this cycle; is_branch  in  1  op is a branch; cond_code  in  4  condition select; is_link  in  1  write link and push stack; is_return  in  1  target from stack; rel_abs  in  1  1 = relative, 0 = absolute; base_addr  in  ADDR_WIDTH  PC of op; rn  in  DATA_WIDTH  register operand; lit  in  DATA_WIDTH  literal offset; flag_z, flag_n, flag_c, flag_v  in  1 each  ALU flags; user_in  in  USER_WIDTH  sideband.
REQ-004 SHALL have downstream ports: out_valid  out  1  result present; out_ready  in  1  consumer accepts; next_pc  out  ADDR_WIDTH  target; next_pc_valid  out  1  branch taken; flush_pipeline  out  1  flush request; link_valid  out  1  link write; link_data  out  DATA_WIDTH  link value; ras_overflow  out  1  push over full stack; ras_underflow  out  1  pop of empty stack; ras_count  out  clog2(RAS_DEPTH)+1  stack occupancy; user_out  out  USER_WIDTH  sideband.

Function
REQ-005 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-006 SHALL accept an op on any rising edge with in_valid && in_ready, branch or not; all outputs SHALL be registered, latency exactly 1 cycle from acceptance to out_valid.
REQ-007 SHALL hold every output stable while out_valid && !out_ready.
REQ-008 SHALL clear out_valid on an edge with out_valid && out_ready && !in_valid.
REQ-009 SHALL decode cond_code as follows. Codes 0-7 SHALL be Z set, Z clr, C set, C clr, V set, V clr, N set, N clr.
REQ-010 Codes 8-15 SHALL be GE (N==V), LT (N!=V), GT (!Z && N==V), LE (Z || N!=V), HI (C && !Z), LS (!C || Z), ALWAYS and NEVER.
REQ-011 SHALL compute taken = is_branch && condition; non-branch ops SHALL give taken = 0.
REQ-012 SHALL select the target as: is_return with a non-empty stack gives the stack top; otherwise rel_abs=1 gives base_addr+lit truncated to ADDR_WIDTH, and rel_abs=0 gives rn[ADDR_WIDTH-1:0].
REQ-013 SHALL register next_pc = target when taken, else 0; next_pc_valid = taken; flush_pipeline = taken; next_pc_valid and flush_pipeline SHALL be qualified by out_valid.
REQ-014 SHALL register link_valid = taken && is_link and link_data = zero-extended (base_addr+LINK_OFFSET) mod 2^ADDR_WIDTH, else 0.
REQ-015 SHALL pass user_in to user_out for every accepted op.
REQ-016 SHALL implement the return stack as a circular buffer with top pointer and count, updated only on accepted taken ops.
REQ-017 Taken is_return with count>0 SHALL pop: count-1.
REQ-018 Taken is_return with count==0 SHALL leave the stack unchanged and set ras_underflow for that result.
REQ-019 Taken is_link with count<RAS_DEPTH SHALL push: count+1.
REQ-020 Taken is_link with count==RAS_DEPTH SHALL overwrite the oldest entry; count SHALL stay at RAS_DEPTH and ras_overflow SHALL be set for that result.
REQ-021 Taken is_link && is_return SHALL read the top for the target, then replace the top with the link value; count SHALL be unchanged, with no overflow or underflow when count>0.
REQ-022 Not-taken ops SHALL leave the stack untouched.
REQ-023 ras_overflow and ras_underflow SHALL be per-result flags, valid with out_valid; ras_count SHALL show the live occupancy.

Reset
REQ-024 Reset SHALL clear, asynchronously: out_valid, next_pc, next_pc_valid, flush_pipeline, link_valid, link_data, ras_overflow, ras_underflow, ras_count, stack pointer and user_out, all to 0; stack entry contents need not be cleared.
REQ-025 Reset asserted mid-operation SHALL discard the pending result; in_ready SHALL be 1 the first cycle after reset deasserts.

Verification
REQ-026 Relative unconditional: base 0x100, lit 0x20, cond 14 -> next 1 cycle out_valid=1, next_pc=0x120, flush_pipeline=1.
REQ-027 Conditional: cond 10 (GT) with Z=0, N=1, V=1 -> taken, target rn=0x400; the same op with Z=1 -> next_pc_valid=0, next_pc=0.
REQ-028 Call/return: link at base 0x200, then return with rn=0 -> link_data=0x202, ras_count goes 1 then 0, and the return gives next_pc=0x202.
REQ-029 Overflow/underflow at RAS_DEPTH=4: five links at 0x10, 0x20, ..., 0x50 -> 5th result ras_overflow=1, count=4.
REQ-030 Continuing REQ-029: five returns -> targets 0x52, 0x42, 0x32, 0x22, then rn with ras_underflow=1.
REQ-031 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs held; out_ready=1 -> one result per cycle, none lost or duplicated.
REQ-032 Reset mid-op: reset asserted with out_valid=1 -> all outputs 0 within the same cycle.
